// File: rtl/verified_accu_feeder_if.sv
// Word-in / beat-out bundle between a word source and the accumulator feeder.
// The feeder sits on the slave side and the word source on the master side.
interface verified_accu_feeder_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BEATS  = 4
);
  localparam int unsigned WORD_W = BEATS * DATA_W;
  localparam int unsigned SUM_W  = DATA_W + $clog2(BEATS);

  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              stall;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              last_out;
  logic [SUM_W-1:0]  sum_out;
  logic              sum_valid;

  modport master (
    output word_in, word_valid, stall,
    input  word_ready, data_out, valid_out, last_out, sum_out, sum_valid
  );

  modport slave (
    input  word_in, word_valid, stall,
    output word_ready, data_out, valid_out, last_out, sum_out, sum_valid
  );
endinterface

// File: rtl/verified_accu_feeder.sv
// Buffers words in a 2-entry FIFO and serialises each into LSB-first beats for
// a 4-beat accumulator, producing the expected group sum alongside.
module verified_accu_feeder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BEATS  = 4,
  parameter int unsigned GAP    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  verified_accu_feeder_if.slave  bus
);
  localparam int unsigned WORD_W = BEATS * DATA_W;
  localparam int unsigned SUM_W  = DATA_W + $clog2(BEATS);
  localparam int unsigned CNT_W  = $clog2(BEATS);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BEATS - 1);
  localparam logic [2:0]       GapLoad  = 3'(GAP);

  // FIFO
  logic [WORD_W-1:0] fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;
  logic              push, pop;
  logic [WORD_W-1:0] head;

  // Serialiser
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [2:0]        gap_q, gap_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              sum_valid_q, sum_valid_d;
  logic [SUM_W-1:0]  sum_q, sum_d;

  assign bus.word_ready = (count_q < 2'd2);
  assign push           = bus.word_valid && bus.word_ready;
  assign head           = fifo_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.word_in;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    gap_d       = gap_q;
    data_d      = data_q;
    sum_d       = sum_q;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    sum_valid_d = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != 2'd0 && !bus.stall) begin
          pop     = 1'b1;
          valid_d = 1'b1;
          data_d  = head[DATA_W-1:0];
          shift_d = head >> DATA_W;
          acc_d   = SUM_W'(head[DATA_W-1:0]);
          beat_d  = CNT_W'(1);
          if (GAP > 0) begin
            state_d = StGap;
            gap_d   = GapLoad;
          end else begin
            state_d = StSend;
          end
        end
      end
      StSend: begin
        if (!bus.stall) begin
          valid_d = 1'b1;
          data_d  = shift_q[DATA_W-1:0];
          shift_d = shift_q >> DATA_W;
          acc_d   = acc_q + SUM_W'(shift_q[DATA_W-1:0]);
          if (beat_q == LastBeat) begin
            last_d      = 1'b1;
            sum_valid_d = 1'b1;
            sum_d       = acc_d;
            beat_d      = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
          if (GAP > 0) begin
            state_d = StGap;
            gap_d   = GapLoad;
          end else if (beat_q == LastBeat) begin
            // Idle pops at the very next edge, so back-to-back words see no bubble.
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        // Gap time elapses even while stalled; stall only blocks the beat itself.
        gap_d = gap_q - 3'd1;
        if (gap_q <= 3'd1) begin
          state_d = (beat_q != '0) ? StSend : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      shift_q     <= '0;
      acc_q       <= '0;
      gap_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      gap_q       <= gap_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      sum_valid_q <= sum_valid_d;
      sum_q       <= sum_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.last_out  = last_q;
  assign bus.sum_out   = sum_q;
  assign bus.sum_valid = sum_valid_q;
endmodule

// File: tb/tb_verified_accu_feeder.sv
// Randomised and directed bench for verified_accu_feeder (GAP = 0 and GAP = 2),
// checked against a rule-level model of the beat stream.
module tb_verified_accu_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;  // 0: exercise GAP=0 instance, 1: GAP=2 instance
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        stall = 1'b0;

  verified_accu_feeder_if if0 ();
  verified_accu_feeder_if if2 ();

  assign if0.word_in    = word_in;
  assign if0.word_valid = word_valid & ~sel;
  assign if0.stall      = stall;
  assign if2.word_in    = word_in;
  assign if2.word_valid = word_valid & sel;
  assign if2.stall      = stall;

  verified_accu_feeder #(.DATA_W(8), .BEATS(4), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  verified_accu_feeder #(.DATA_W(8), .BEATS(4), .GAP(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic       obs_ready, obs_valid, obs_last, obs_sv;
  logic [7:0] obs_data;
  logic [9:0] obs_sum;
  assign obs_ready = sel ? if2.word_ready : if0.word_ready;
  assign obs_valid = sel ? if2.valid_out  : if0.valid_out;
  assign obs_last  = sel ? if2.last_out   : if0.last_out;
  assign obs_sv    = sel ? if2.sum_valid  : if0.sum_valid;
  assign obs_data  = sel ? if2.data_out   : if0.data_out;
  assign obs_sum   = sel ? if2.sum_out    : if0.sum_out;

  int checks = 0;
  int errors = 0;

  // Model state: queued words, word in flight, beat position, edges since last beat.
  logic [31:0] fifo[$];
  logic [31:0] cur;
  int          beat_idx;
  int          since;
  int          gap;
  logic [7:0]  last_data;
  logic [9:0]  last_sum;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] byte_sum(input logic [31:0] w);
    return 10'(w[7:0]) + 10'(w[15:8]) + 10'(w[23:16]) + 10'(w[31:24]);
  endfunction

  task automatic model_clear();
    fifo.delete();
    cur       = '0;
    beat_idx  = 0;
    since     = 255;
    last_data = '0;
    last_sum  = '0;
  endtask

  // One clock edge: predict, advance, then compare all outputs.
  task automatic tick();
    logic        exp_v;
    logic        do_push;
    logic [31:0] pushed;
    logic [7:0]  b;
    check_eq("word_ready", obs_ready, fifo.size() < 2);
    do_push = word_valid && (fifo.size() < 2);
    pushed  = word_in;
    exp_v   = !stall && (beat_idx != 0 || fifo.size() != 0) && (since >= gap);
    @(posedge clk);
    #1;
    check_eq("valid_out", obs_valid, exp_v);
    if (exp_v) begin
      if (beat_idx == 0) cur = fifo.pop_front();
      b = cur[8*beat_idx +: 8];
      check_eq("data_out", obs_data, b);
      check_eq("last_out", obs_last, beat_idx == 3);
      check_eq("sum_valid", obs_sv, beat_idx == 3);
      if (beat_idx == 3) last_sum = byte_sum(cur);
      last_data = b;
      since     = 0;
      beat_idx  = (beat_idx + 1) % 4;
    end else begin
      check_eq("last_out_idle", obs_last, 0);
      check_eq("sum_valid_idle", obs_sv, 0);
      check_eq("data_out_hold", obs_data, last_data);
      if (since < 255) since++;
    end
    check_eq("sum_out", obs_sum, last_sum);
    if (do_push) fifo.push_back(pushed);
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear at once.
  task automatic reset_dut();
    word_valid = 1'b0;
    stall      = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_eq("rst_valid", obs_valid, 0);
    check_eq("rst_data", obs_data, 0);
    check_eq("rst_last", obs_last, 0);
    check_eq("rst_sum", obs_sum, 0);
    check_eq("rst_sum_valid", obs_sv, 0);
    check_eq("rst_ready", obs_ready, 1);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      word_valid = ($urandom % 2) == 0;
      stall      = ($urandom % 4) == 0;
      word_in    = $urandom;
      tick();
    end
    word_valid = 1'b0;
    stall      = 1'b0;
    repeat (40) tick();
  endtask

  initial begin
    logic [31:0] w;
    int          n;
    gap = 0;
    model_clear();
    #1;
    reset_dut();

    // Single word.
    word_in = 32'h04030201; word_valid = 1'b1; tick();
    word_valid = 1'b0;
    repeat (6) tick();
    check_eq("single_sum", obs_sum, 10);

    // Max values back-to-back.
    word_valid = 1'b1;
    word_in = 32'hFFFFFFFF; tick();
    word_in = 32'h00000080; tick();
    word_valid = 1'b0;
    repeat (4) tick();
    check_eq("max_sum", obs_sum, 1020);
    repeat (6) tick();
    check_eq("max_sum2", obs_sum, 128);

    // FIFO full under stall.
    stall = 1'b1; word_valid = 1'b1;
    word_in = 32'h11111111; tick();
    word_in = 32'h22222222; tick();
    word_in = 32'h33333333; tick();
    check_eq("full_ready", obs_ready, 0);
    stall = 1'b0;
    n = 0;
    while (fifo.size() >= 2 && n < 20) begin
      tick();
      n++;
    end
    check_eq("full_accept_bound", n < 20, 1);
    tick();
    word_valid = 1'b0;
    repeat (16) tick();
    check_eq("full_sum", obs_sum, byte_sum(32'h33333333));

    // Mid-word stall after beat 1.
    word_in = 32'h40302010; word_valid = 1'b1; tick();
    word_valid = 1'b0;
    tick();
    tick();
    stall = 1'b1; repeat (3) tick();
    stall = 1'b0; repeat (5) tick();
    check_eq("stall_sum", obs_sum, 10'h0A0);

    random_run(300);

    // Reset after beat 2 with one word queued.
    word_valid = 1'b1;
    word_in = 32'hA1B2C3D4; tick();
    word_in = 32'h55667788; tick();
    word_valid = 1'b0;
    n = 0;
    while (beat_idx != 3 && n < 10) begin
      tick();
      n++;
    end
    check_eq("rst_reach_beat2", beat_idx, 3);
    reset_dut();
    repeat (6) tick();
    w = $urandom;
    word_in = w; word_valid = 1'b1; tick();
    word_valid = 1'b0;
    repeat (6) tick();
    check_eq("post_rst_sum", obs_sum, byte_sum(w));

    // GAP = 2 instance.
    sel = 1'b1;
    gap = 2;
    reset_dut();
    word_in = 32'h01010101; word_valid = 1'b1; tick();
    word_valid = 1'b0;
    repeat (14) tick();
    check_eq("gap_sum", obs_sum, 4);
    random_run(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
